// File: rtl/hazard_fwd_ctrl_pkg.sv
// Shared encodings for the hazard/forwarding controller: forward selects,
// FSM states and shadow-stage field widths.
package haz_pkg;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    localparam int unsigned REG_AW_DEF = 5;
    localparam int unsigned FLUSH_CW   = 2;

    typedef enum logic {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } state_t;

endpackage

// File: rtl/hazard_fwd_ctrl_fwd_sel.sv
// Per-operand forward select: compares one EX source index against the
// MEM and WB shadow destinations. MEM wins over WB; index 0 never forwards.
module fwd_sel_unit
    import haz_pkg::*;
#(
    parameter int unsigned REG_AW = REG_AW_DEF
) (
    input  logic              ex_valid,
    input  logic [REG_AW-1:0] src,
    input  logic              mem_valid,
    input  logic              mem_reg_write,
    input  logic [REG_AW-1:0] mem_rd,
    input  logic              wb_valid,
    input  logic              wb_reg_write,
    input  logic [REG_AW-1:0] wb_rd,
    output logic [1:0]        sel
);

    always_comb begin
        sel = FWD_RF;
        if (ex_valid) begin
            if (mem_valid && mem_reg_write && (mem_rd != '0) && (mem_rd == src))
                sel = FWD_MEM;
            else if (wb_valid && wb_reg_write && (wb_rd != '0) && (wb_rd == src))
                sel = FWD_WB;
        end
    end

endmodule

// File: rtl/hazard_fwd_ctrl.sv
// EX operand forwarding selects, load-use stall and taken-branch flush control.
// Optional perf counters are built only when HAZ_PERF_CNT_EN is defined.
module hazard_fwd_ctrl
    import haz_pkg::*;
#(
    parameter int unsigned REG_AW       = REG_AW_DEF,
    parameter int unsigned FLUSH_CYCLES = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic              id_uses_rt,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              id_reg_write,
    input  logic              id_mem_read,
    input  logic              ex_branch_taken,
    output logic [1:0]        fwd_a_sel,
    output logic [1:0]        fwd_b_sel,
    output logic              pc_hold,
    output logic              ifid_hold,
    output logic              idex_bubble,
    output logic              ifid_flush,
    output logic [31:0]       stall_cnt,
    output logic [31:0]       flush_cnt
);

    localparam logic [FLUSH_CW-1:0] FLUSH_LOAD = FLUSH_CW'(FLUSH_CYCLES - 1);

    logic              ex_valid, ex_reg_write, ex_mem_read;
    logic [REG_AW-1:0] ex_rs, ex_rt, ex_rd;
    logic              mem_valid, mem_reg_write;
    logic [REG_AW-1:0] mem_rd;
    logic              wb_valid, wb_reg_write;
    logic [REG_AW-1:0] wb_rd;

    state_t             state;
    logic [FLUSH_CW-1:0] flush_left;

    logic hazard, branch_evt, flush_act, stall;

    always_comb begin
        hazard = id_valid && ex_valid && ex_mem_read && (ex_rd != '0) &&
                 ((ex_rd == id_rs) || (id_uses_rt && (ex_rd == id_rt)));
        branch_evt = (state == RUN) && ex_branch_taken;
        flush_act  = (state == FLUSH) || branch_evt;
        // A same-cycle taken branch overrides the stall so the PC takes the target.
        stall      = (state == RUN) && hazard && !ex_branch_taken;
    end

    assign pc_hold     = stall;
    assign ifid_hold   = stall;
    assign idex_bubble = stall || flush_act;
    assign ifid_flush  = flush_act;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ex_valid      <= 1'b0;
            ex_reg_write  <= 1'b0;
            ex_mem_read   <= 1'b0;
            ex_rs         <= '0;
            ex_rt         <= '0;
            ex_rd         <= '0;
            mem_valid     <= 1'b0;
            mem_reg_write <= 1'b0;
            mem_rd        <= '0;
            wb_valid      <= 1'b0;
            wb_reg_write  <= 1'b0;
            wb_rd         <= '0;
        end else begin
            ex_valid      <= id_valid && !idex_bubble;
            ex_reg_write  <= id_reg_write;
            ex_mem_read   <= id_mem_read;
            ex_rs         <= id_rs;
            ex_rt         <= id_rt;
            ex_rd         <= id_rd;
            mem_valid     <= ex_valid;
            mem_reg_write <= ex_reg_write;
            mem_rd        <= ex_rd;
            wb_valid      <= mem_valid;
            wb_reg_write  <= mem_reg_write;
            wb_rd         <= mem_rd;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= RUN;
            flush_left <= '0;
        end else begin
            case (state)
                RUN: begin
                    if (branch_evt) begin
                        flush_left <= FLUSH_LOAD;
                        if (FLUSH_CYCLES > 1)
                            state <= FLUSH;
                    end
                end
                FLUSH: begin
                    flush_left <= flush_left - 1'b1;
                    if (flush_left <= FLUSH_CW'(1))
                        state <= RUN;
                end
                default: state <= RUN;
            endcase
        end
    end

    fwd_sel_unit #(.REG_AW(REG_AW)) u_fwd_a (
        .ex_valid      (ex_valid),
        .src           (ex_rs),
        .mem_valid     (mem_valid),
        .mem_reg_write (mem_reg_write),
        .mem_rd        (mem_rd),
        .wb_valid      (wb_valid),
        .wb_reg_write  (wb_reg_write),
        .wb_rd         (wb_rd),
        .sel           (fwd_a_sel)
    );

    fwd_sel_unit #(.REG_AW(REG_AW)) u_fwd_b (
        .ex_valid      (ex_valid),
        .src           (ex_rt),
        .mem_valid     (mem_valid),
        .mem_reg_write (mem_reg_write),
        .mem_rd        (mem_rd),
        .wb_valid      (wb_valid),
        .wb_reg_write  (wb_reg_write),
        .wb_rd         (wb_rd),
        .sel           (fwd_b_sel)
    );

`ifdef HAZ_PERF_CNT_EN
    logic [31:0] stall_q, flush_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            if (stall)
                stall_q <= stall_q + 32'd1;
            if (branch_evt)
                flush_q <= flush_q + 32'd1;
        end
    end

    assign stall_cnt = stall_q;
    assign flush_cnt = flush_q;
`else
    assign stall_cnt = '0;
    assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_hazard_fwd_ctrl.sv
// Bench for hazard_fwd_ctrl (FLUSH_CYCLES=2): directed vector table, then random
// stimulus against a stage-list reference model. Honours HAZ_PERF_CNT_EN.
module tb_hazard_fwd_ctrl;

    localparam int FC = 2;
`ifdef HAZ_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        id_valid = 1'b0, id_uses_rt = 1'b0, id_reg_write = 1'b0, id_mem_read = 1'b0;
    logic [4:0]  id_rs = '0, id_rt = '0, id_rd = '0;
    logic        ex_branch_taken = 1'b0;
    logic [1:0]  fwd_a_sel, fwd_b_sel;
    logic        pc_hold, ifid_hold, idex_bubble, ifid_flush;
    logic [31:0] stall_cnt, flush_cnt;

    always #5 clk = ~clk;

    hazard_fwd_ctrl #(.REG_AW(5), .FLUSH_CYCLES(FC)) dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_uses_rt(id_uses_rt), .id_rd(id_rd), .id_reg_write(id_reg_write),
        .id_mem_read(id_mem_read), .ex_branch_taken(ex_branch_taken),
        .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel), .pc_hold(pc_hold),
        .ifid_hold(ifid_hold), .idex_bubble(idex_bubble), .ifid_flush(ifid_flush),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    typedef struct {
        logic       rst_n, vld;
        logic [4:0] rs, rt;
        logic       ut;
        logic [4:0] rd;
        logic       rw, mr, br, chk;
        logic [1:0] a, b;
        logic       hold, bub, flush;
    } vec_t;

    typedef struct {
        bit v;
        int rs, rt, rd;
        bit rw, mr;
    } ins_t;

    int n_chk = 0, n_fail = 0;

    // Reference: list of in-flight instructions, index 0 = EX, 1 = MEM, 2 = WB.
    ins_t pipe[3];
    int   m_fl = 0, m_stalls = 0, m_flushes = 0;

    function automatic vec_t mk(int r, int vl, int s, int t, int u, int d, int w, int m, int br,
                                int c, int a, int b, int h, int bb, int f);
        vec_t v;
        v.rst_n = r[0]; v.vld = vl[0]; v.rs = s[4:0]; v.rt = t[4:0]; v.ut = u[0];
        v.rd = d[4:0]; v.rw = w[0]; v.mr = m[0]; v.br = br[0]; v.chk = c[0];
        v.a = a[1:0]; v.b = b[1:0]; v.hold = h[0]; v.bub = bb[0]; v.flush = f[0];
        return v;
    endfunction

    function automatic vec_t idle(int a, int b, int h, int bb, int f);
        return mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, a, b, h, bb, f);
    endfunction

    // Nearest older stage writing src: MEM -> 2, WB -> 1, none -> 0.
    function automatic int fwd_exp(int src);
        if (!pipe[0].v) return 0;
        for (int s = 1; s <= 2; s++)
            if (pipe[s].v && pipe[s].rw && pipe[s].rd != 0 && pipe[s].rd == src)
                return (s == 1) ? 2 : 1;
        return 0;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int s = 0; s < 3; s++) pipe[s] = '{v: 0, rs: 0, rt: 0, rd: 0, rw: 0, mr: 0};
        m_fl = 0; m_stalls = 0; m_flushes = 0;
    endtask

    task automatic step(input vec_t v, input bit use_tbl);
        bit in_fl, bevt, hz, e_hold, e_flush, e_bub;
        int e_a, e_b;
        @(negedge clk);
        rst_n = v.rst_n; id_valid = v.vld; id_rs = v.rs; id_rt = v.rt; id_uses_rt = v.ut;
        id_rd = v.rd; id_reg_write = v.rw; id_mem_read = v.mr; ex_branch_taken = v.br;
        #1;
        in_fl   = (m_fl > 0);
        bevt    = !in_fl && v.br;
        hz      = !in_fl && v.vld && pipe[0].v && pipe[0].mr && pipe[0].rd != 0 &&
                  (pipe[0].rd == int'(v.rs) || (v.ut && pipe[0].rd == int'(v.rt)));
        e_hold  = hz && !bevt;
        e_flush = in_fl || bevt;
        e_bub   = e_hold || e_flush;
        e_a     = fwd_exp(int'(v.rs) * 0 + pipe[0].rs);
        e_b     = fwd_exp(pipe[0].rt);
        if (use_tbl) begin
            if (v.chk) begin
                check("tbl fwd_a_sel",   32'(fwd_a_sel),   32'(v.a));
                check("tbl fwd_b_sel",   32'(fwd_b_sel),   32'(v.b));
                check("tbl pc_hold",     32'(pc_hold),     32'(v.hold));
                check("tbl ifid_hold",   32'(ifid_hold),   32'(v.hold));
                check("tbl idex_bubble", 32'(idex_bubble), 32'(v.bub));
                check("tbl ifid_flush",  32'(ifid_flush),  32'(v.flush));
            end
        end else begin
            check("rnd fwd_a_sel",   32'(fwd_a_sel),   32'(e_a));
            check("rnd fwd_b_sel",   32'(fwd_b_sel),   32'(e_b));
            check("rnd pc_hold",     32'(pc_hold),     32'(e_hold));
            check("rnd ifid_hold",   32'(ifid_hold),   32'(e_hold));
            check("rnd idex_bubble", 32'(idex_bubble), 32'(e_bub));
            check("rnd ifid_flush",  32'(ifid_flush),  32'(e_flush));
        end
        @(posedge clk);
        if (!v.rst_n) begin
            model_reset();
        end else begin
            pipe[2] = pipe[1];
            pipe[1] = pipe[0];
            pipe[0] = '{v: v.vld && !e_bub, rs: int'(v.rs), rt: int'(v.rt), rd: int'(v.rd),
                        rw: v.rw, mr: v.mr};
            m_fl = bevt ? FC - 1 : (in_fl ? m_fl - 1 : 0);
            if (e_hold) m_stalls++;
            if (bevt) m_flushes++;
        end
    endtask

    task automatic check_counters(input string tag, input int es, input int ef);
        #1;
        check({tag, " stall_cnt"}, stall_cnt, PERF ? 32'(es) : 32'd0);
        check({tag, " flush_cnt"}, flush_cnt, PERF ? 32'(ef) : 32'd0);
    endtask

    vec_t tbl[$];
    int   seg1_end;

    initial begin
        model_reset();
        // reset, then quiet cycle with every output low
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(idle(0, 0, 0, 0, 0));
        // back-to-back dependency on r3: MEM forward
        tbl.push_back(mk(1, 1, 1, 2, 1, 3, 1, 0, 0, 1, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 1, 3, 4, 1, 8, 1, 0, 0, 1, 0, 0, 0, 0, 0));
        tbl.push_back(idle(2, 0, 0, 0, 0));
        // one gap: WB forward on operand B
        tbl.push_back(mk(1, 1, 1, 2, 1, 3, 1, 0, 0, 1, 0, 0, 0, 0, 0));
        tbl.push_back(idle(0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 1, 9, 3, 1, 10, 1, 0, 0, 1, 0, 0, 0, 0, 0));
        tbl.push_back(idle(0, 1, 0, 0, 0));
        // two gaps: value already in regfile
        tbl.push_back(mk(1, 1, 1, 2, 1, 3, 1, 0, 0, 1, 0, 0, 0, 0, 0));
        tbl.push_back(idle(0, 0, 0, 0, 0));
        tbl.push_back(idle(0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 1, 3, 0, 0, 11, 1, 0, 0, 1, 0, 0, 0, 0, 0));
        tbl.push_back(idle(0, 0, 0, 0, 0));
        // two writers of r3 in flight: MEM beats WB
        tbl.push_back(mk(1, 1, 1, 2, 1, 3, 1, 0, 0, 1, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 1, 1, 2, 1, 3, 1, 0, 0, 1, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 1, 3, 3, 1, 12, 1, 0, 0, 1, 0, 0, 0, 0, 0));
        tbl.push_back(idle(2, 2, 0, 0, 0));
        // LW r5; ADD r6,r5,r7: one stall cycle, load reaches WB when ADD enters EX
        tbl.push_back(mk(1, 1, 1, 0, 0, 5, 1, 1, 0, 1, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 1, 5, 7, 1, 6, 1, 0, 0, 1, 0, 0, 1, 1, 0));
        tbl.push_back(mk(1, 1, 5, 7, 1, 6, 1, 0, 0, 1, 0, 0, 0, 0, 0));
        tbl.push_back(idle(1, 0, 0, 0, 0));
        // r0 writers then r0 reader; LW r0 causes no stall
        tbl.push_back(mk(1, 1, 1, 2, 1, 0, 1, 0, 0, 1, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 1, 1, 2, 1, 0, 1, 0, 0, 1, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 1, 0, 0, 1, 13, 1, 0, 0, 1, 0, 0, 0, 0, 0));
        tbl.push_back(idle(0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 1, 1, 0, 0, 0, 1, 1, 0, 1, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 1, 0, 0, 1, 14, 1, 0, 0, 1, 0, 0, 0, 0, 0));
        tbl.push_back(idle(0, 0, 0, 0, 0));
        // taken branch held high: exactly two flush cycles
        tbl.push_back(mk(1, 1, 1, 2, 1, 14, 1, 0, 1, 1, 0, 0, 0, 1, 1));
        tbl.push_back(mk(1, 1, 1, 2, 1, 14, 1, 0, 1, 1, 0, 0, 0, 1, 1));
        tbl.push_back(idle(0, 0, 0, 0, 0));
        // branch in the same cycle as a load-use: no hold
        tbl.push_back(mk(1, 1, 1, 0, 0, 5, 1, 1, 0, 1, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 1, 5, 0, 0, 6, 1, 0, 1, 1, 0, 0, 0, 1, 1));
        tbl.push_back(mk(1, 1, 5, 0, 0, 6, 1, 0, 0, 1, 0, 0, 0, 1, 1));
        tbl.push_back(idle(0, 0, 0, 0, 0));
        // load-use on rt, then rt match ignored when id_uses_rt=0, then rs stall
        tbl.push_back(mk(1, 1, 1, 0, 0, 7, 1, 1, 0, 1, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 1, 2, 7, 1, 8, 1, 0, 0, 1, 0, 0, 1, 1, 0));
        tbl.push_back(mk(1, 1, 2, 7, 1, 8, 1, 0, 0, 1, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 1, 1, 0, 0, 9, 1, 1, 0, 1, 0, 1, 0, 0, 0));
        tbl.push_back(mk(1, 1, 2, 9, 0, 10, 1, 0, 0, 1, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 1, 1, 0, 0, 11, 1, 1, 0, 1, 0, 2, 0, 0, 0));
        tbl.push_back(mk(1, 1, 11, 0, 0, 12, 1, 0, 0, 1, 0, 0, 1, 1, 0));
        tbl.push_back(mk(1, 1, 11, 0, 0, 12, 1, 0, 0, 1, 0, 0, 0, 0, 0));
        seg1_end = tbl.size();
        // reset in the middle of a flush
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 0, 0, 1, 1));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(idle(0, 0, 0, 0, 0));
        tbl.push_back(idle(0, 0, 0, 0, 0));

        check_counters("pre", 0, 0);
        for (int i = 0; i < tbl.size(); i++) begin
            if (i == 2) check_counters("after reset", 0, 0);
            if (i == seg1_end) check_counters("directed", 3, 2);
            step(tbl[i], 1'b1);
        end
        check_counters("after mid-flush reset", 0, 0);

        begin
            vec_t v;
            v = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
            step(v, 1'b0);
            for (int c = 0; c < 3000; c++) begin
                v = mk(($urandom_range(0, 199) != 0) ? 1 : 0,
                       ($urandom_range(0, 3) != 0) ? 1 : 0,
                       $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 1),
                       $urandom_range(0, 7), $urandom_range(0, 1),
                       ($urandom_range(0, 2) == 0) ? 1 : 0,
                       ($urandom_range(0, 11) == 0) ? 1 : 0,
                       1, 0, 0, 0, 0, 0);
                step(v, 1'b0);
            end
            check_counters("random", m_stalls, m_flushes);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
